// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - write-side pointer, full, level, almost-full and overflow status of the async FIFO
module wptr_full #(
    parameter int ADDRSIZE    = 4,
    parameter int AFULL_LEVEL = 2**ADDRSIZE - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AFULL = (ADDRSIZE+1)'(AFULL_LEVEL);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] wlevel_next;
    logic              wen;
    logic              wfull_next;

    assign wen       = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign waddr     = wbin[ADDRSIZE-1:0];

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign wfull_next  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign wlevel_next = wbinnext - rbin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            wlevel       <= wlevel_next;
            walmost_full <= (wlevel_next >= AFULL);
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - randomized self-checking bench for wptr_full against a counting model
module tb_wptr_full;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = 5'd0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic       woverflow;

    wptr_full #(.ADDRSIZE(4), .AFULL_LEVEL(14)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .wlevel(wlevel),
        .walmost_full(walmost_full), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    int errors = 0;
    int checks = 0;

    // Absolute (unwrapped) counts of writes accepted and reads seen by the write side.
    int  m_wr = 0;
    int  rd_drv = 0;
    int  e_level = 0;
    bit  e_full = 0, e_af = 0, e_ovf = 0;
    int  e_waddr = 0;
    logic [4:0] e_wptr = 5'd0;
    bit  started = 0;
    bit  was_reset = 0;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = b[4:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wclk) begin
        started   = 1;
        was_reset = !wrst_n;
        if (!wrst_n) begin
            m_wr = 0; e_level = 0; e_full = 0; e_af = 0; e_ovf = 0;
        end else begin
            if (winc && e_full) e_ovf = 1;
            if (winc && !e_full) m_wr++;
            e_level = m_wr - rd_drv;
            e_full  = (e_level == 16);
            e_af    = (e_level >= 14);
        end
        e_waddr = m_wr % 16;
        e_wptr  = gray(m_wr % 32);
    end

    logic [4:0] prev_wptr = 5'd0;
    always @(negedge wclk) begin
        if (started) begin
            chk("level", int'(wlevel), e_level);
            chk("full", int'(wfull), int'(e_full));
            chk("almost_full", int'(walmost_full), int'(e_af));
            chk("overflow", int'(woverflow), int'(e_ovf));
            chk("waddr", int'(waddr), e_waddr);
            chk("wptr", int'(wptr), int'(e_wptr));
            chk("full_invariant", int'(wfull), int'(wlevel == 5'd16));
            if (!was_reset) chk("wptr_one_bit", int'($countones(wptr ^ prev_wptr) <= 1), 1);
            prev_wptr = wptr;
        end
    end

    task automatic drive(input logic w, input int radv, input logic rst);
        @(negedge wclk);
        wrst_n = rst;
        winc   = w;
        if (!rst) rd_drv = 0;
        else if (rd_drv + radv <= m_wr) rd_drv += radv;
        wq2_rptr = gray(rd_drv);
        @(posedge wclk);
        #1;
    endtask

    initial begin
        // Reset with winc held high
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk("rst_level", int'(wlevel), 0);
        chk("rst_wptr", int'(wptr), 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        chk("idle_waddr", int'(waddr), 0);

        // Fill with no reads
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 1);
            chk("fill_level_lit", int'(wlevel), i);
            if (i == 13) chk("af_before_14", int'(walmost_full), 0);
            if (i == 14) chk("af_at_14", int'(walmost_full), 1);
            if (i == 15) chk("not_full_15", int'(wfull), 0);
        end
        chk("full_lit", int'(wfull), 1);
        chk("full_wptr_lit", int'(wptr), int'(5'b11000));
        chk("full_waddr_lit", int'(waddr), 0);

        // Overflow while full
        for (int i = 0; i < 3; i++) drive(1, 0, 1);
        chk("ovf_lit", int'(woverflow), 1);
        chk("ovf_level_lit", int'(wlevel), 16);
        chk("ovf_wptr_lit", int'(wptr), int'(5'b11000));

        // Drain: read pointer jumps to 4
        drive(0, 4, 1);
        chk("drain_full_lit", int'(wfull), 0);
        chk("drain_level_lit", int'(wlevel), 12);
        chk("drain_af_lit", int'(walmost_full), 0);
        chk("ovf_sticky_lit", int'(woverflow), 1);

        // Simultaneous write and read at level 8
        drive(0, 4, 1);
        chk("lvl8_lit", int'(wlevel), 8);
        drive(1, 1, 1);
        chk("simul_level_lit", int'(wlevel), 8);
        chk("simul_full_lit", int'(wfull), 0);

        // Wrap: 40 matched write/read steps
        for (int i = 0; i < 40; i++) drive(1, 1, 1);
        chk("wrap_level_lit", int'(wlevel), 8);

        // Random traffic with a mid-run reset
        for (int i = 0; i < 600; i++) begin
            logic w;
            int   r;
            if (i < 300) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
            end else begin
                w = ($urandom_range(0, 2) == 0);
                r = int'($urandom_range(0, 2));
            end
            drive(w, r, (i == 250) ? 1'b0 : 1'b1);
            if (i == 250) chk("midrst_ovf_lit", int'(woverflow), 0);
        end

        drive(0, 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
